// File: rtl/joystick_serial_pkg.sv
// Shared types, frame layout and frame-image builder for the serial joystick target.
package joystick_serial_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic PAD_BIT    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Bit positions within the shifted frame; position 0 leaves first.
    localparam int POS_P1_UP    = 0;
    localparam int POS_P1_FIRE1 = 1;
    localparam int POS_P1_DOWN  = 2;
    localparam int POS_P1_LEFT  = 3;
    localparam int POS_P1_RIGHT = 4;
    localparam int POS_P1_FIRE2 = 5;
    localparam int POS_PAD0     = 6;
    localparam int POS_PAD1     = 7;
    localparam int POS_P2_UP    = 8;
    localparam int POS_P2_FIRE1 = 9;
    localparam int POS_P2_DOWN  = 10;
    localparam int POS_P2_LEFT  = 11;
    localparam int POS_P2_RIGHT = 12;
    localparam int POS_P2_FIRE2 = 13;
    localparam int POS_PAD2     = 14;
    localparam int POS_PAD3     = 15;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire1;
        logic fire2;
    } joy_btn_t;

    typedef enum logic {
        LINK_IDLE   = 1'b0,
        LINK_ACTIVE = 1'b1
    } link_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input joy_btn_t p1,
                                                          input joy_btn_t p2);
        logic [FRAME_BITS-1:0] f;
        f               = '0;
        f[POS_P1_UP]    = p1.up;
        f[POS_P1_FIRE1] = p1.fire1;
        f[POS_P1_DOWN]  = p1.down;
        f[POS_P1_LEFT]  = p1.left;
        f[POS_P1_RIGHT] = p1.right;
        f[POS_P1_FIRE2] = p1.fire2;
        f[POS_PAD0]     = PAD_BIT;
        f[POS_PAD1]     = PAD_BIT;
        f[POS_P2_UP]    = p2.up;
        f[POS_P2_FIRE1] = p2.fire1;
        f[POS_P2_DOWN]  = p2.down;
        f[POS_P2_LEFT]  = p2.left;
        f[POS_P2_RIGHT] = p2.right;
        f[POS_P2_FIRE2] = p2.fire2;
        f[POS_PAD2]     = PAD_BIT;
        f[POS_PAD3]     = PAD_BIT;
        return f;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] sync_p0;
    logic         level_p1;

    // Synchronizer chain, then one extra flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0  <= '1;
            level_p1 <= 1'b1;
        end else begin
            sync_p0  <= {sync_p0[N-2:0], async_i};
            level_p1 <= sync_p0[N-1];
        end
    end

    assign level_o = sync_p0[N-1];
    assign rise_o  = sync_p0[N-1] & ~level_p1;
    assign fall_o  = ~sync_p0[N-1] & level_p1;

endmodule

// File: rtl/joystick_serial_tx.sv
// Serial joystick link target: parallel-load on host load strobe, shift out on host clock.
// Optional autofire on fire1 is enabled by defining JOYSTICK_SERIAL_TX_AUTOFIRE_EN.
module joystick_serial_tx
    import joystick_serial_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int AUTOFIRE_FRAMES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic joy_clk_i,
    input  logic joy_load_i,
    output logic joy_data_o,
    input  logic joy1_up_i,
    input  logic joy1_down_i,
    input  logic joy1_left_i,
    input  logic joy1_right_i,
    input  logic joy1_fire1_i,
    input  logic joy1_fire2_i,
    input  logic joy2_up_i,
    input  logic joy2_down_i,
    input  logic joy2_left_i,
    input  logic joy2_right_i,
    input  logic joy2_fire1_i,
    input  logic joy2_fire2_i,
    output logic link_active_o,
    output logic frame_o
);

    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (v == TMO_MAX) ? v : v + TMO_W'(1);
    endfunction

    logic clk_rise;
    logic clk_level_unused;
    logic clk_fall_unused;
    logic load_level;
    logic load_rel;
    logic load_fall_unused;
    logic load_act;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (joy_clk_i),
        .level_o (clk_level_unused),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (joy_load_i),
        .level_o (load_level),
        .rise_o  (load_rel),
        .fall_o  (load_fall_unused)
    );

    assign load_act = ~load_level;
    assign frame_o  = load_rel;

    logic af_phase;

`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
    localparam int AF_N = (AUTOFIRE_FRAMES < 1) ? 1 : AUTOFIRE_FRAMES;
    localparam int AF_W = (AF_N > 1) ? $clog2(AF_N) : 1;

    logic [AF_W-1:0] af_cnt_q;
    logic            af_phase_q;

    // Autofire phase flips every AF_N completed frames
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else if (load_rel) begin
            if (af_cnt_q == AF_W'(AF_N - 1)) begin
                af_cnt_q   <= '0;
                af_phase_q <= ~af_phase_q;
            end else begin
                af_cnt_q <= af_cnt_q + AF_W'(1);
            end
        end
    end

    assign af_phase = af_phase_q;
`else
    // Autofire period is only meaningful in the autofire build.
    logic unused_af_cfg;
    assign unused_af_cfg = (AUTOFIRE_FRAMES > 0);
    assign af_phase      = 1'b0;
`endif

    joy_btn_t               p1_btn;
    joy_btn_t               p2_btn;
    logic [FRAME_BITS-1:0]  frame_img;

    // A pressed fire1 (0) is released (1) during the autofire off phase
    always_comb begin
        p1_btn.up    = joy1_up_i;
        p1_btn.down  = joy1_down_i;
        p1_btn.left  = joy1_left_i;
        p1_btn.right = joy1_right_i;
        p1_btn.fire1 = joy1_fire1_i | af_phase;
        p1_btn.fire2 = joy1_fire2_i;
        p2_btn.up    = joy2_up_i;
        p2_btn.down  = joy2_down_i;
        p2_btn.left  = joy2_left_i;
        p2_btn.right = joy2_right_i;
        p2_btn.fire1 = joy2_fire1_i | af_phase;
        p2_btn.fire2 = joy2_fire2_i;
    end

    assign frame_img = build_frame(p1_btn, p2_btn);

    logic [FRAME_BITS-1:0] frame_sr;

    // Load has priority over a coincident host clock edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_sr <= {FRAME_BITS{IDLE_LEVEL}};
        end else if (load_act) begin
            frame_sr <= frame_img;
        end else if (clk_rise) begin
            frame_sr <= {PAD_BIT, frame_sr[FRAME_BITS-1:1]};
        end
    end

    link_state_t      link_q;
    link_state_t      link_nxt;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            link_q <= LINK_IDLE;
            tmo_q  <= '0;
        end else begin
            link_q <= link_nxt;
            tmo_q  <= tmo_nxt;
        end
    end

    always_comb begin
        tmo_nxt  = load_act ? '0 : sat_inc(tmo_q);
        link_nxt = link_q;
        case (link_q)
            LINK_IDLE: begin
                if (load_act) link_nxt = LINK_ACTIVE;
            end
            LINK_ACTIVE: begin
                if (!load_act && tmo_nxt == TMO_MAX) link_nxt = LINK_IDLE;
            end
            default: link_nxt = LINK_IDLE;
        endcase
    end

    assign link_active_o = (link_q == LINK_ACTIVE);
    assign joy_data_o    = link_active_o ? frame_sr[0] : IDLE_LEVEL;

endmodule

// File: tb/tb_joystick_serial_tx.sv
// Scoreboard bench for joystick_serial_tx: a host model loads and clocks frames, expected bits are queued per frame.
module tb_joystick_serial_tx;

    localparam int HALF = 6;
    localparam int AF   = 2;

    logic clk_i      = 1'b0;
    logic rst_i      = 1'b1;
    logic joy_clk_i  = 1'b0;
    logic joy_load_i = 1'b1;
    logic [11:0] btn = 12'hFFF;

    logic joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_fire1_i, joy1_fire2_i;
    logic joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_fire1_i, joy2_fire2_i;
    logic joy_data_o, link_active_o, frame_o;
    logic wd_data, wd_link, wd_frame;

    assign {joy2_fire2_i, joy2_fire1_i, joy2_right_i, joy2_left_i, joy2_down_i, joy2_up_i,
            joy1_fire2_i, joy1_fire1_i, joy1_right_i, joy1_left_i, joy1_down_i, joy1_up_i} = btn;

    always #5 clk_i = ~clk_i;

    joystick_serial_tx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1000), .AUTOFIRE_FRAMES(AF)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .joy_clk_i(joy_clk_i), .joy_load_i(joy_load_i),
        .joy_data_o(joy_data_o),
        .joy1_up_i(joy1_up_i), .joy1_down_i(joy1_down_i), .joy1_left_i(joy1_left_i),
        .joy1_right_i(joy1_right_i), .joy1_fire1_i(joy1_fire1_i), .joy1_fire2_i(joy1_fire2_i),
        .joy2_up_i(joy2_up_i), .joy2_down_i(joy2_down_i), .joy2_left_i(joy2_left_i),
        .joy2_right_i(joy2_right_i), .joy2_fire1_i(joy2_fire1_i), .joy2_fire2_i(joy2_fire2_i),
        .link_active_o(link_active_o), .frame_o(frame_o)
    );

    // Second instance with a short watchdog for the timeout scenario
    joystick_serial_tx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .AUTOFIRE_FRAMES(AF)) dut_wd (
        .clk_i(clk_i), .rst_i(rst_i), .joy_clk_i(joy_clk_i), .joy_load_i(joy_load_i),
        .joy_data_o(wd_data),
        .joy1_up_i(joy1_up_i), .joy1_down_i(joy1_down_i), .joy1_left_i(joy1_left_i),
        .joy1_right_i(joy1_right_i), .joy1_fire1_i(joy1_fire1_i), .joy1_fire2_i(joy1_fire2_i),
        .joy2_up_i(joy2_up_i), .joy2_down_i(joy2_down_i), .joy2_left_i(joy2_left_i),
        .joy2_right_i(joy2_right_i), .joy2_fire1_i(joy2_fire1_i), .joy2_fire2_i(joy2_fire2_i),
        .link_active_o(wd_link), .frame_o(wd_frame)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   frame_cnt = 0;
    int   wd_frame_cnt = 0;
    int   rel_cnt = 0;
    logic exp_q[$];
`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
    int   af_rel = 0;
`endif

    always @(negedge clk_i) begin
        if (frame_o)  frame_cnt++;
        if (wd_frame) wd_frame_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic cur_phase();
`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
        return ((af_rel / AF) % 2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Independent model of the frame layout, indexed by the btn vector
    function automatic logic [15:0] model_frame(input logic [11:0] b, input logic ph);
        logic [15:0] f;
        f     = 16'hFFFF;
        f[0]  = b[0];
        f[1]  = b[4] | ph;
        f[2]  = b[1];
        f[3]  = b[2];
        f[4]  = b[3];
        f[5]  = b[5];
        f[8]  = b[6];
        f[9]  = b[10] | ph;
        f[10] = b[7];
        f[11] = b[8];
        f[12] = b[9];
        f[13] = b[11];
        return f;
    endfunction

    task automatic push_frame(input int nbits);
        logic [15:0] f;
        f = model_frame(btn, cur_phase());
        for (int i = 0; i < nbits; i++) exp_q.push_back((i < 16) ? f[i] : 1'b1);
    endtask

    task automatic push_ones(input int nbits);
        for (int i = 0; i < nbits; i++) exp_q.push_back(1'b1);
    endtask

    task automatic sample(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, joy_data_o);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, 32'(joy_data_o), 32'(e));
        end
    endtask

    task automatic note_release();
        rel_cnt++;
`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
        af_rel++;
`endif
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        wait_cyc(3);
        rst_i = 1'b0;
`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
        af_rel = 0;
`endif
    endtask

    task automatic host_load();
        joy_load_i = 1'b0;
        wait_cyc(HALF);
        joy_load_i = 1'b1;
        note_release();
        wait_cyc(HALF);
    endtask

    task automatic host_clock(input string tag);
        joy_clk_i = 1'b1;
        wait_cyc(HALF);
        sample(tag);
        joy_clk_i = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic read_frame(input string name, input int nbits);
        push_frame(nbits);
        host_load();
        sample($sformatf("%s.pos0", name));
        for (int i = 1; i < nbits; i++) host_clock($sformatf("%s.pos%0d", name, i));
        check_val({name, ".link"}, 32'(link_active_o), 32'(1));
        check_val({name, ".frames"}, 32'(frame_cnt), 32'(rel_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wait_cyc(2);
        do_reset();

        // Idle host after reset
        wait_cyc(40);
        check_val("idle.data", 32'(joy_data_o), 32'(1));
        check_val("idle.link", 32'(link_active_o), 32'(0));
        check_val("idle.frames", 32'(frame_cnt), 32'(0));
        push_ones(3);
        for (int i = 0; i < 3; i++) host_clock($sformatf("noload.pos%0d", i));

        btn = 12'hFFE;
        read_frame("p1up", 16);
        check_val("p1up.one_frame", 32'(frame_cnt), 32'(1));

        btn = 12'h7FF;
        read_frame("p2f2", 16);

        for (int k = 0; k < 3; k++) begin
            btn = 12'($urandom);
            read_frame($sformatf("rnd%0d", k), (k == 2) ? 20 : 16);
        end

        // One-cycle load coincident with a host clock rise: load must win
        btn = 12'hFFE;
        push_frame(3);
        joy_load_i = 1'b0;
        joy_clk_i  = 1'b1;
        wait_cyc(1);
        joy_load_i = 1'b1;
        note_release();
        wait_cyc(HALF);
        sample("coinc.pos0");
        joy_clk_i = 1'b0;
        wait_cyc(HALF);
        host_clock("coinc.pos1");
        host_clock("coinc.pos2");
        check_val("coinc.frames", 32'(frame_cnt), 32'(rel_cnt));

        // Watchdog instance: active just after a load, drops near 100 idle cycles
        btn = 12'hFFE;
        host_load();
        wait_cyc(80);
        check_val("wd.link_before", 32'(wd_link), 32'(1));
        check_val("wd.data_before", 32'(wd_data), 32'(0));
        wait_cyc(30);
        check_val("wd.link_after", 32'(wd_link), 32'(0));
        check_val("wd.data_forced", 32'(wd_data), 32'(1));
        check_val("main.data_held", 32'(joy_data_o), 32'(0));
        host_load();
        check_val("wd.link_again", 32'(wd_link), 32'(1));
        check_val("wd.data_again", 32'(wd_data), 32'(0));
        check_val("wd.frames", 32'(wd_frame_cnt), 32'(rel_cnt));

        // Reset in the middle of a frame after position 5
        btn = 12'h000;
        push_frame(6);
        host_load();
        sample("midrst.pos0");
        for (int i = 1; i < 6; i++) host_clock($sformatf("midrst.pos%0d", i));
        rst_i = 1'b1;
        wait_cyc(1);
        rst_i = 1'b0;
`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
        af_rel = 0;
`endif
        check_val("midrst.data", 32'(joy_data_o), 32'(1));
        check_val("midrst.link", 32'(link_active_o), 32'(0));
        push_ones(10);
        for (int i = 6; i < 16; i++) host_clock($sformatf("midrst.pos%0d", i));
        read_frame("postrst", 16);

`ifdef JOYSTICK_SERIAL_TX_AUTOFIRE_EN
        begin
            logic af_exp[6];
            af_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            do_reset();
            btn = 12'hFEF;
            for (int f = 0; f < 6; f++) begin
                exp_q.push_back(1'b1);
                exp_q.push_back(af_exp[f]);
                host_load();
                sample($sformatf("af%0d.pos0", f));
                host_clock($sformatf("af%0d.pos1", f));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
